// File: rtl/prog_loader_mem.sv
// prog_loader_mem
//   Loads a program image from a UART byte stream and serves it as
//   instruction memory. The stream is one header byte H (word count minus 1),
//   followed by (H+1)*WORD_BYTES data bytes, most significant byte of each
//   word first. Only whole words are written. Words beyond H keep their old
//   contents.
//
//   Build option: define PROG_LOADER_CHECKSUM_EN to expect one more byte after
//   the data. That byte must equal the modulo-256 sum of all data bytes.
//
// Ports
//   CLK             in   clock, rising edge
//   RESETN          in   asynchronous active-low reset (memory is not reset)
//   rx_valid        in   one-cycle strobe, rx_data carries a received byte
//   rx_data         in   [7:0] received byte
//   reload          in   one-cycle strobe, abort/restart loading
//   program_counter in   [ADDR_W-1:0] read address
//   instruction     out  [8*WORD_BYTES-1:0] mem[program_counter], combinational
//   load_done       out  last load completed without error
//   load_error      out  last load failed (bad header, timeout, checksum)
//   words_loaded    out  [ADDR_W:0] words committed in the current/last load
module prog_loader_mem #(
  parameter int WORD_BYTES     = 2,
  parameter int DEPTH          = 32,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    reload,
  input  logic [ADDR_W-1:0]       program_counter,
  output logic [8*WORD_BYTES-1:0] instruction,
  output logic                    load_done,
  output logic                    load_error,
  output logic [ADDR_W:0]         words_loaded
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   h_q;
  logic [ADDR_W-1:0]   write_addr_q;
  logic [IDX_W-1:0]    byte_idx_q;
  logic [IDLE_W-1:0]   idle_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic [WORD_W-1:0]   asm_q;
  logic [WORD_W-1:0]   mem [DEPTH];

  logic [WORD_W-1:0]   asm_next;
  logic                byte_take;
  logic                word_last;
  logic                mem_we;
  logic                load_last;
  logic                hdr_bad;
  logic                idle_expire;

  // Bytes arrive MSB first, so shifting each new byte in from the bottom
  // leaves the first byte in the top lane once the word is complete.
  assign asm_next    = WORD_W'({asm_q, rx_data});
  assign byte_take   = rx_valid && !reload && (state_q == S_DATA);
  assign word_last   = (byte_idx_q == LAST_IDX);
  assign mem_we      = byte_take && word_last;
  assign load_last   = (write_addr_q == h_q);
  assign hdr_bad     = ({1'b0, rx_data} >= 9'(DEPTH));
  assign idle_expire = (idle_q == IDLE_LAST);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= S_HDR;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      h_q          <= '0;
      write_addr_q <= '0;
      byte_idx_q   <= '0;
      idle_q       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else if (reload) begin
      // reload wins over a byte in the same cycle; that byte is dropped
      state_q      <= S_HDR;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      write_addr_q <= '0;
      byte_idx_q   <= '0;
      idle_q       <= '0;
    end else begin
      case (state_q)
        S_HDR: begin
          if (rx_valid) begin
            if (hdr_bad) begin
              state_q    <= S_ERR;
              load_error <= 1'b1;
              load_done  <= 1'b0;
            end else begin
              state_q      <= S_DATA;
              h_q          <= rx_data[ADDR_W-1:0];
              write_addr_q <= '0;
              byte_idx_q   <= '0;
              words_loaded <= '0;
              idle_q       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
              csum_q       <= '0;
`endif
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            idle_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q + rx_data;
`endif
            if (word_last) begin
              byte_idx_q   <= '0;
              write_addr_q <= write_addr_q + 1'b1;
              words_loaded <= words_loaded + 1'b1;
              if (load_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state_q   <= S_CSUM;
`else
                state_q   <= S_DONE;
                load_done <= 1'b1;
`endif
              end
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end else if (idle_expire) begin
            state_q    <= S_ERR;
            load_error <= 1'b1;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_valid) begin
            idle_q <= '0;
            if (rx_data == csum_q) begin
              state_q   <= S_DONE;
              load_done <= 1'b1;
            end else begin
              state_q    <= S_ERR;
              load_error <= 1'b1;
            end
          end else if (idle_expire) begin
            state_q    <= S_ERR;
            load_error <= 1'b1;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
`endif

        S_DONE, S_ERR: begin
          // terminal until reload; incoming bytes are ignored
        end

        default: state_q <= S_HDR;
      endcase
    end
  end

  // Word assembly and memory are data only: no reset, so a reset in the
  // middle of a load keeps every word already written.
  always_ff @(posedge CLK) begin
    if (byte_take) begin
      asm_q <= asm_next;
    end
    if (mem_we) begin
      mem[write_addr_q] <= asm_next;
    end
  end

  always_comb begin
    instruction = '0;
    if ({1'b0, program_counter} < DEPTH_EXT) begin
      instruction = mem[program_counter];
    end
  end

endmodule

// File: tb/tb_prog_loader_mem.sv
`timescale 1ns/1ps
module tb_prog_loader_mem;

  localparam int TO = 40;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESETN;
  logic [7:0]  rx_data;
  logic [2:0]  rv;
  logic [2:0]  rl;

  logic [4:0]  pc_a;
  logic [15:0] ins_a;
  logic        done_a, err_a;
  logic [5:0]  words_a;

  logic [2:0]  pc_b;
  logic [31:0] ins_b;
  logic        done_b, err_b;
  logic [3:0]  words_b;

  logic [2:0]  pc_c;
  logic [7:0]  ins_c;
  logic        done_c, err_c;
  logic [3:0]  words_c;

  prog_loader_mem #(.WORD_BYTES(2), .DEPTH(32), .ADDR_W(5), .TIMEOUT_CYCLES(TO)) u_a (
    .CLK(CLK), .RESETN(RESETN), .rx_valid(rv[0]), .rx_data(rx_data), .reload(rl[0]),
    .program_counter(pc_a), .instruction(ins_a), .load_done(done_a),
    .load_error(err_a), .words_loaded(words_a));

  prog_loader_mem #(.WORD_BYTES(4), .DEPTH(8), .ADDR_W(3), .TIMEOUT_CYCLES(TO)) u_b (
    .CLK(CLK), .RESETN(RESETN), .rx_valid(rv[1]), .rx_data(rx_data), .reload(rl[1]),
    .program_counter(pc_b), .instruction(ins_b), .load_done(done_b),
    .load_error(err_b), .words_loaded(words_b));

  prog_loader_mem #(.WORD_BYTES(1), .DEPTH(5), .ADDR_W(3), .TIMEOUT_CYCLES(TO)) u_c (
    .CLK(CLK), .RESETN(RESETN), .rx_valid(rv[2]), .rx_data(rx_data), .reload(rl[2]),
    .program_counter(pc_c), .instruction(ins_c), .load_done(done_c),
    .load_error(err_c), .words_loaded(words_c));

  int n_checks = 0;
  int n_errors = 0;

  // reference image of instance a
  logic [15:0] ref_a [32];
  bit          known_a [32];
  logic [7:0]  q [$];
  logic [7:0]  vals [5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int inst, input logic [7:0] b);
    rx_data   = b;
    rv[inst]  = 1'b1;
    tick();
    rv[inst]  = 1'b0;
  endtask

  task automatic pulse_reload(input int inst);
    rl[inst] = 1'b1;
    tick();
    rl[inst] = 1'b0;
  endtask

  // sends header + data with small random gaps, plus the checksum byte when enabled
  task automatic send_stream(input int inst, input logic [7:0] s[$]);
    int sum;
    sum = 0;
    foreach (s[i]) begin
      send(inst, s[i]);
      if (i > 0) sum += int'(s[i]);
      repeat ($urandom_range(0, 2)) tick();
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send(inst, 8'(sum));
`endif
  endtask

  task automatic check_mem_a(input string tag);
    for (int i = 0; i < 32; i++) begin
      if (known_a[i]) begin
        pc_a = 5'(i);
        tick();
        check($sformatf("%s_mem%0d", tag, i), ins_a, ref_a[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  h;
    logic [15:0] word;
    int          csum;
    bit          bad, exp_done;
    logic [31:0] w32;

    RESETN  = 1'b0;
    rx_data = 8'h00;
    rv      = '0;
    rl      = '0;
    pc_a    = '0;
    pc_b    = '0;
    pc_c    = '0;
    foreach (known_a[i]) known_a[i] = 1'b0;

    #3;
    check("rst_done_a", done_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_words_a", words_a, 0);
    check("rst_flags_b", {done_b, err_b, words_b}, 0);
    check("rst_flags_c", {done_c, err_c, words_c}, 0);
    tick();
    tick();
    RESETN = 1'b1;
    tick();

    // two-word load
    q = {8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_stream(0, q);
    check("basic_done", done_a, 1);
    check("basic_err", err_a, 0);
    check("basic_words", words_a, 2);
    ref_a[0] = 16'h1234; known_a[0] = 1'b1;
    ref_a[1] = 16'hABCD; known_a[1] = 1'b1;
    check_mem_a("basic");

    // idle timeout after one word and one stray byte
    pulse_reload(0);
    send(0, 8'h01); send(0, 8'h56); send(0, 8'h78); send(0, 8'h9A);
    check("to_words_mid", words_a, 1);
    repeat (TO - 1) tick();
    check("to_err_before", err_a, 0);
    tick();
    check("to_err_after", err_a, 1);
    check("to_done", done_a, 0);
    check("to_words", words_a, 1);
    ref_a[0] = 16'h5678;
    check_mem_a("to");

    // reload beats a simultaneous byte
    pulse_reload(0);
    q = {8'h00, 8'h11, 8'h22};
    send_stream(0, q);
    check("rl_pre_done", done_a, 1);
    rl[0] = 1'b1; rv[0] = 1'b1; rx_data = 8'h55;
    tick();
    rl[0] = 1'b0; rv[0] = 1'b0;
    check("rl_done", done_a, 0);
    check("rl_err", err_a, 0);
    check("rl_words", words_a, 0);
    q = {8'h00, 8'h33, 8'h44};
    send_stream(0, q);
    check("rl_post_done", done_a, 1);
    check("rl_post_words", words_a, 1);
    ref_a[0] = 16'h3344;

    // header equal to DEPTH is rejected with no write
    pulse_reload(0);
    send(0, 8'h20);
    check("hdr_err", err_a, 1);
    check("hdr_done", done_a, 0);
    check("hdr_words", words_a, 0);
    send(0, 8'h00);
    send(0, 8'h99);
    check("hdr_err_hold", err_a, 1);
    check_mem_a("hdr");

`ifdef PROG_LOADER_CHECKSUM_EN
    pulse_reload(0);
    send(0, 8'h00); send(0, 8'h10); send(0, 8'h20); send(0, 8'h30);
    check("cs_good_done", done_a, 1);
    pulse_reload(0);
    send(0, 8'h00); send(0, 8'h10); send(0, 8'h20); send(0, 8'h31);
    check("cs_bad_err", err_a, 1);
    check("cs_bad_done", done_a, 0);
`else
    pulse_reload(0);
    send(0, 8'h00); send(0, 8'h10); send(0, 8'h20);
    check("nocs_done", done_a, 1);
    send(0, 8'h30);
    check("nocs_done_hold", done_a, 1);
    check("nocs_words", words_a, 1);
`endif
    ref_a[0] = 16'h1020;
    pc_a = 5'd0;
    tick();
    check("cs_mem0", ins_a, 16'h1020);

    // randomized loads against the reference image
    for (int it = 0; it < 10; it++) begin
      pulse_reload(0);
      check($sformatf("rnd%0d_clr", it), {done_a, err_a, words_a}, 0);
      bad = ($urandom_range(0, 5) == 0);
      h = bad ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      send(0, h);
      if (bad) begin
        check($sformatf("rnd%0d_hdr_err", it), err_a, 1);
        check($sformatf("rnd%0d_hdr_words", it), words_a, 0);
        check_mem_a($sformatf("rnd%0d", it));
        continue;
      end
      csum = 0;
      for (int w = 0; w <= int'(h); w++) begin
        word = 16'($urandom());
        pc_a = 5'(w);
        send(0, word[15:8]);
        repeat ($urandom_range(0, 3)) tick();
        send(0, word[7:0]);
        check($sformatf("rnd%0d_live%0d", it, w), ins_a, word);
        check($sformatf("rnd%0d_cnt%0d", it, w), words_a, 6'(w + 1));
        ref_a[w]   = word;
        known_a[w] = 1'b1;
        csum += int'(word[15:8]) + int'(word[7:0]);
        repeat ($urandom_range(0, 3)) tick();
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      exp_done = ($urandom_range(0, 2) != 0);
      send(0, exp_done ? 8'(csum) : 8'(csum + $urandom_range(1, 255)));
`else
      exp_done = 1'b1;
`endif
      send(0, 8'hFF);
      check($sformatf("rnd%0d_done", it), done_a, exp_done);
      check($sformatf("rnd%0d_err", it), err_a, !exp_done);
      check($sformatf("rnd%0d_words", it), words_a, 6'(int'(h) + 1));
      check_mem_a($sformatf("rnd%0d", it));
    end

    // 32-bit words, reset in the middle of a load
    q = {8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_stream(1, q);
    check("w4_done", done_b, 1);
    check("w4_words", words_b, 1);
    pc_b = 3'd0;
    tick();
    check("w4_mem0", ins_b, 32'hDEADBEEF);
    pulse_reload(1);
    send(1, 8'h01);
    send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(1, 8'h44);
    send(1, 8'h55);
    check("w4_mid_words", words_b, 1);
    RESETN = 1'b0;
    #2;
    check("w4_rst_async", {done_b, err_b, words_b}, 0);
    tick();
    RESETN = 1'b1;
    tick();
    check("w4_rst_mem0", ins_b, 32'h11223344);
    q = {8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'hB6, 8'hC7, 8'hD8};
    send_stream(1, q);
    check("w4_post_done", done_b, 1);
    check("w4_post_words", words_b, 2);
    pc_b = 3'd0;
    tick();
    check("w4_post_mem0", ins_b, 32'h01020304);
    pc_b = 3'd1;
    tick();
    w32 = 32'hA5B6C7D8;
    check("w4_post_mem1", ins_b, w32);

    // byte-wide words, non power-of-two depth
    q = {8'h04};
    for (int i = 0; i < 5; i++) begin
      vals[i] = 8'($urandom());
      q.push_back(vals[i]);
    end
    send_stream(2, q);
    check("w1_done", done_c, 1);
    check("w1_words", words_c, 5);
    for (int i = 0; i < 8; i++) begin
      pc_c = 3'(i);
      tick();
      check($sformatf("w1_pc%0d", i), ins_c, (i < 5) ? vals[i] : 8'h00);
    end
    pulse_reload(2);
    check("w1_rl_words", words_c, 0);
    send(2, 8'h05);
    check("w1_hdr_err", err_c, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
